dcache_sa_top: RTL and testbench

//  Parametrised N-way set-associative, write-back, write-allocate data cache; successor of the direct-mapped dcache.

---
 rtl/dcache_pkg.sv | 30 +++
 rtl/dcache_sa_way.sv | 60 ++++++
 rtl/dcache_sa_top.sv | 179 +++++++++++++++++
 tb/tb_dcache_sa_top.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared state encoding and address field widths for the set-associative dcache
package dcache_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MISS     = 3'd1,
        S_WB       = 3'd2,
        S_GAP      = 3'd3,
        S_REFILL   = 3'd4,
        S_REFILLOK = 3'd5
    } state_t;

    function automatic int off_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int sets, input int line_bytes);
        return addr_w - $clog2(sets) - $clog2(line_bytes);
    endfunction

    // A direct-mapped build still needs a 1-bit way pointer.
    function automatic int sel_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/dcache_sa_way.sv
// rtl/dcache_sa_way.sv - one cache way: tag/valid/dirty/data arrays, tag compare and word write
module dcache_sa_way
    import dcache_pkg::*;
#(
    parameter int SETS   = 32,
    parameter int IDX_W  = 5,
    parameter int TAG_W  = 22,
    parameter int LINE_W = 256,
    parameter int WSEL_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic              i_word_we,
    input  logic [WSEL_W-1:0] i_word_sel,
    input  logic [31:0]       i_word_data,
    input  logic              i_fill_we,
    input  logic [LINE_W-1:0] i_fill_line,
    output logic              o_hit,
    output logic              o_valid,
    output logic              o_dirty,
    output logic [TAG_W-1:0]  o_tag,
    output logic [LINE_W-1:0] o_line
);

    logic [SETS-1:0]   r_valid;
    logic [SETS-1:0]   r_dirty;
    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [LINE_W-1:0] r_data [SETS];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill_we) begin
            r_valid[i_idx] <= 1'b1;
            r_dirty[i_idx] <= 1'b0;
        end else if (i_word_we) begin
            r_dirty[i_idx] <= 1'b1;
        end
    end

    // Payload arrays need no reset: nothing reads them while the valid bit is clear.
    always_ff @(posedge clk_i) begin
        if (i_fill_we) begin
            r_tag[i_idx]  <= i_tag;
            r_data[i_idx] <= i_fill_line;
        end else if (i_word_we) begin
            r_data[i_idx][32*i_word_sel +: 32] <= i_word_data;
        end
    end

    assign o_valid = r_valid[i_idx];
    assign o_dirty = r_dirty[i_idx];
    assign o_tag   = r_tag[i_idx];
    assign o_line  = r_data[i_idx];
    assign o_hit   = r_valid[i_idx] && (r_tag[i_idx] == i_tag);

endmodule

// File: rtl/dcache_sa_top.sv
// rtl/dcache_sa_top.sv - N-way write-back write-allocate data cache: FSM, victim select, counters
module dcache_sa_top
    import dcache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 32,
    parameter int SETS       = 32,
    parameter int WAYS       = 2,
    parameter int CNT_W      = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ADDR_W-1:0]       p1_addr_i,
    input  logic [31:0]             p1_data_i,
    input  logic                    p1_MemRead_i,
    input  logic                    p1_MemWrite_i,
    output logic [31:0]             p1_data_o,
    output logic                    p1_stall_o,
    output logic [ADDR_W-1:0]       mem_addr_o,
    output logic [8*LINE_BYTES-1:0] mem_data_o,
    output logic                    mem_enable_o,
    output logic                    mem_write_o,
    input  logic [8*LINE_BYTES-1:0] mem_data_i,
    input  logic                    mem_ack_i,
    output logic [CNT_W-1:0]        hit_cnt_o,
    output logic [CNT_W-1:0]        miss_cnt_o
);

    localparam int OFF_W  = off_w(LINE_BYTES);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_W, SETS, LINE_BYTES);
    localparam int LINE_W = 8 * LINE_BYTES;
    localparam int WSEL_W = OFF_W - 2;
    localparam int RR_W   = sel_w(WAYS);

    state_t            r_state;
    state_t            w_next;
    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [WSEL_W-1:0] w_wsel;
    logic              w_req;
    logic              w_hit;
    logic              w_store_ok;
    logic              w_full;
    logic              w_fill_done;
    logic [WAYS-1:0]   w_hit_vec;
    logic [WAYS-1:0]   w_valid_vec;
    logic [WAYS-1:0]   w_dirty_vec;
    logic [WAYS-1:0]   w_fill_we;
    logic [WAYS-1:0]   w_word_we;
    logic [TAG_W-1:0]  w_tag_arr  [WAYS];
    logic [LINE_W-1:0] w_line_arr [WAYS];
    logic [LINE_W-1:0] w_hit_line;
    logic [RR_W-1:0]   w_victim;
    logic [RR_W-1:0]   r_victim;
    logic              r_full;
    logic [RR_W-1:0]   r_rr [SETS];
    logic [CNT_W-1:0]  r_hit_cnt;
    logic [CNT_W-1:0]  r_miss_cnt;
    logic              w_unused;

    assign w_idx       = p1_addr_i[OFF_W +: IDX_W];
    assign w_tag       = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign w_wsel      = p1_addr_i[OFF_W-1:2];
    assign w_unused    = ^p1_addr_i[1:0];
    assign w_req       = p1_MemRead_i | p1_MemWrite_i;
    assign w_hit       = |w_hit_vec;
    assign w_full      = &w_valid_vec;
    assign w_store_ok  = p1_MemWrite_i && ((r_state == S_IDLE) || (r_state == S_REFILLOK));
    assign w_fill_done = (r_state == S_REFILL) && mem_ack_i;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        assign w_fill_we[g] = w_fill_done && (r_victim == RR_W'(g));
        assign w_word_we[g] = w_store_ok && w_hit_vec[g];

        dcache_sa_way #(
            .SETS   (SETS),
            .IDX_W  (IDX_W),
            .TAG_W  (TAG_W),
            .LINE_W (LINE_W),
            .WSEL_W (WSEL_W)
        ) u_way (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .i_idx       (w_idx),
            .i_tag       (w_tag),
            .i_word_we   (w_word_we[g]),
            .i_word_sel  (w_wsel),
            .i_word_data (p1_data_i),
            .i_fill_we   (w_fill_we[g]),
            .i_fill_line (mem_data_i),
            .o_hit       (w_hit_vec[g]),
            .o_valid     (w_valid_vec[g]),
            .o_dirty     (w_dirty_vec[g]),
            .o_tag       (w_tag_arr[g]),
            .o_line      (w_line_arr[g])
        );
    end

    always_comb begin
        w_hit_line = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (w_hit_vec[w]) w_hit_line = w_line_arr[w];
        end
    end

    // Lowest invalid way wins; a full set falls back to its round-robin pointer.
    always_comb begin
        w_victim = r_rr[w_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!w_valid_vec[w]) w_victim = RR_W'(w);
        end
    end

    assign p1_data_o  = w_hit_line[32*w_wsel +: 32];
    assign p1_stall_o = rst_i & w_req & ~w_hit;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_req && !w_hit) w_next = S_MISS;
            S_MISS:     w_next = (w_valid_vec[w_victim] && w_dirty_vec[w_victim]) ? S_WB : S_REFILL;
            S_WB:       if (mem_ack_i) w_next = S_GAP;
            S_GAP:      w_next = S_REFILL;
            S_REFILL:   if (mem_ack_i) w_next = S_REFILLOK;
            S_REFILLOK: w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        case (r_state)
            S_WB: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {w_tag_arr[r_victim], w_idx, {OFF_W{1'b0}}};
                mem_data_o   = w_line_arr[r_victim];
            end
            S_REFILL: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {w_tag, w_idx, {OFF_W{1'b0}}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_victim   <= '0;
            r_full     <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
        end else begin
            if (r_state == S_MISS) begin
                r_victim <= w_victim;
                r_full   <= w_full;
            end
            if (w_fill_done && r_full) begin
                r_rr[w_idx] <= (r_rr[w_idx] == RR_W'(WAYS - 1)) ? '0 : r_rr[w_idx] + 1'b1;
            end
            if (w_req && w_hit && (r_state != S_REFILLOK)) r_hit_cnt <= r_hit_cnt + 1'b1;
            if ((r_state == S_IDLE) && w_req && !w_hit) r_miss_cnt <= r_miss_cnt + 1'b1;
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;

endmodule

// File: tb/tb_dcache_sa_top.sv
// tb/tb_dcache_sa_top.sv - scoreboard bench for dcache_sa_top with a line-wide memory responder
module tb_dcache_sa_top;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  p1_addr_i;
    logic [31:0]  p1_data_i;
    logic         p1_MemRead_i;
    logic         p1_MemWrite_i;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;

    always #5 clk_i = ~clk_i;

    dcache_sa_top u_dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .p1_addr_i     (p1_addr_i),
        .p1_data_i     (p1_data_i),
        .p1_MemRead_i  (p1_MemRead_i),
        .p1_MemWrite_i (p1_MemWrite_i),
        .p1_data_o     (p1_data_o),
        .p1_stall_o    (p1_stall_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_o    (mem_data_o),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i),
        .hit_cnt_o     (hit_cnt_o),
        .miss_cnt_o    (miss_cnt_o)
    );

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
    } mem_req_t;

    mem_req_t     mem_q[$];
    logic [31:0]  data_q[$];
    logic [255:0] mem_model [logic [31:0]];
    logic [31:0]  cpu_model [logic [31:0]];
    int           n_checks = 0;
    int           n_fail   = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] init_line(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = {base[15:0], 8'hA5, 8'(k)};
        return l;
    endfunction

    function automatic logic [255:0] get_line(input logic [31:0] base);
        if (mem_model.exists(base)) return mem_model[base];
        return init_line(base);
    endfunction

    // CPU-visible golden value: last store to the word, else backing memory.
    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [255:0] l;
        int           w;
        if (cpu_model.exists(a)) return cpu_model[a];
        l = get_line({a[31:5], 5'b0});
        w = int'(a[4:2]);
        return l[32*w +: 32];
    endfunction

    function automatic logic [255:0] exp_line(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = exp_word(base + 32'(4*k));
        return l;
    endfunction

    task automatic exp_mem(input logic wr, input logic [31:0] addr);
        mem_req_t r;
        r.wr   = wr;
        r.addr = addr;
        mem_q.push_back(r);
    endtask

    task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic exp_stall, input string tag);
        int          cyc;
        int          lat;
        int          gap_cnt;
        bit          inflight;
        bit          gap_on;
        logic        cur_wr;
        logic [31:0] cur_addr;
        mem_req_t    r;
        @(posedge clk_i); #1;
        p1_addr_i     = a;
        p1_data_i     = wd;
        p1_MemRead_i  = !wr;
        p1_MemWrite_i = wr;
        if (!wr) data_q.push_back(exp_word(a));
        cyc = 0; lat = 0; gap_cnt = 0; inflight = 0; gap_on = 0;
        cur_wr = 1'b0; cur_addr = '0;
        @(negedge clk_i);
        check({tag, "_stall"}, p1_stall_o, exp_stall);
        if (!exp_stall) check({tag, "_noen"}, mem_enable_o, 0);
        while (p1_stall_o && cyc < 200) begin
            if (mem_enable_o) begin
                if (!inflight) begin
                    inflight = 1; lat = 0;
                    cur_wr   = mem_write_o;
                    cur_addr = mem_addr_o;
                    if (gap_on) begin
                        check({tag, "_gap"}, gap_cnt, 1);
                        gap_on = 0;
                    end
                    if (mem_q.size() == 0) begin
                        check({tag, "_mem_extra"}, mem_addr_o, '1);
                    end else begin
                        r = mem_q.pop_front();
                        check({tag, "_mem_wr"}, mem_write_o, r.wr);
                        check({tag, "_mem_addr"}, mem_addr_o, r.addr);
                    end
                    if (mem_write_o) check({tag, "_wb_line"}, mem_data_o, exp_line(mem_addr_o));
                end else begin
                    lat++;
                end
                if (lat == 2) begin
                    mem_ack_i = 1'b1;
                    if (cur_wr) begin
                        mem_model[cur_addr] = mem_data_o;
                        gap_on  = 1;
                        gap_cnt = 0;
                    end else begin
                        mem_data_i = get_line(cur_addr);
                    end
                    inflight = 0;
                end
            end else if (gap_on) begin
                gap_cnt++;
            end
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            cyc++;
        end
        check({tag, "_done"}, p1_stall_o, 0);
        if (!wr) check({tag, "_data"}, p1_data_o, data_q.pop_front());
        else     cpu_model[a] = wd;
        @(posedge clk_i); #1;
        p1_MemRead_i  = 1'b0;
        p1_MemWrite_i = 1'b0;
    endtask

    initial begin
        logic [255:0] l;
        mem_req_t     r;
        int           cyc;
        rst_i = 1'b0;
        p1_addr_i = '0; p1_data_i = '0; p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
        mem_data_i = '0; mem_ack_i = 1'b0;
        l = init_line(32'h40);
        l[95:64] = 32'hDEADBEEF;
        mem_model[32'h40] = l;

        repeat (3) @(negedge clk_i);
        check("rst_stall", p1_stall_o, 0);
        check("rst_en", mem_enable_o, 0);
        check("rst_wr", mem_write_o, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_data", p1_data_o, 0);
        check("rst_hits", hit_cnt_o, 0);
        check("rst_miss", miss_cnt_o, 0);
        rst_i = 1'b1;

        exp_mem(0, 32'h40);
        access(0, 32'h48, 32'h0, 1, "t1");
        check("t1_miss", miss_cnt_o, 1);
        check("t1_hits", hit_cnt_o, 0);

        access(1, 32'h44, 32'h12345678, 0, "t2w");
        access(0, 32'h44, 32'h0, 0, "t2r");
        check("t2_hits", hit_cnt_o, 2);

        exp_mem(0, 32'h440);
        access(0, 32'h440, 32'h0, 1, "t3m");
        access(0, 32'h40, 32'h0, 0, "t3a");
        access(0, 32'h440, 32'h0, 0, "t3b");
        check("t3_miss", miss_cnt_o, 2);
        check("t3_hits", hit_cnt_o, 4);

        exp_mem(1, 32'h40);
        exp_mem(0, 32'h840);
        access(0, 32'h840, 32'h0, 1, "t4");
        check("t4_miss", miss_cnt_o, 3);

        exp_mem(0, 32'hC40);
        access(0, 32'hC40, 32'h0, 1, "t5");
        check("t5_miss", miss_cnt_o, 4);
        check("t5_hits", hit_cnt_o, 4);
        check("t5_q", mem_q.size(), 0);

        access(1, 32'h848, 32'hCAFEF00D, 0, "t6w");
        check("t6_hits", hit_cnt_o, 5);
        exp_mem(1, 32'h840);
        @(posedge clk_i); #1;
        p1_addr_i = 32'h40; p1_MemRead_i = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk_i);
            cyc++;
        end while (!mem_enable_o && cyc < 20);
        check("t6_wb_en", mem_enable_o, 1);
        r = mem_q.pop_front();
        check("t6_wb_wr", mem_write_o, r.wr);
        check("t6_wb_addr", mem_addr_o, r.addr);
        #2 rst_i = 1'b0;
        #1;
        check("t6_rst_en", mem_enable_o, 0);
        check("t6_rst_hits", hit_cnt_o, 0);
        check("t6_rst_miss", miss_cnt_o, 0);
        p1_MemRead_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        cpu_model.delete();

        exp_mem(0, 32'h840);
        access(0, 32'h840, 32'h0, 1, "t6r");
        check("t6_miss", miss_cnt_o, 1);
        access(0, 32'h848, 32'h0, 0, "t6d");
        exp_mem(0, 32'h40);
        access(0, 32'h44, 32'h0, 1, "t6o");
        check("t6_end_miss", miss_cnt_o, 2);
        check("t6_end_hits", hit_cnt_o, 1);
        check("end_q", mem_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
